// File: rtl/decoder_pkg.sv
// Shared widths and a reference one-hot helper for the 4-to-16 decoder slice.
package decoder_pkg;

    localparam int SEL_W = 4;
    localparam int N_OUT = 16;

    function automatic logic [N_OUT-1:0] onehot16(input logic [SEL_W-1:0] sel, input logic en);
        logic [N_OUT-1:0] v;
        v = '0;
        if (en) begin
            v[sel] = 1'b1;
        end
        return v;
    endfunction

endpackage

// File: rtl/decoder_2to4.sv
// Combinational 2-to-4 one-hot decoder with enable; the building block of the 4-to-16 tree.
module decoder_2to4 (
    input  logic [1:0] sel,
    input  logic       en,
    output logic [3:0] y
);

    always_comb begin
        y = 4'b0000;
        if (en) begin
            y[sel] = 1'b1;
        end
    end

endmodule

// File: rtl/decoder_4to16.sv
// Registered 4-to-16 line decoder: a two-level 2-to-4 tree feeding 16 output flops.
module decoder_4to16
    import decoder_pkg::*;
#(
    parameter bit OUT_ACTIVE_LOW = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic d,
    input  logic c,
    input  logic b,
    input  logic a,
    output logic y0,
    output logic y1,
    output logic y2,
    output logic y3,
    output logic y4,
    output logic y5,
    output logic y6,
    output logic y7,
    output logic y8,
    output logic y9,
    output logic y10,
    output logic y11,
    output logic y12,
    output logic y13,
    output logic y14,
    output logic y15
);

    localparam logic [N_OUT-1:0] POL_MASK = {N_OUT{OUT_ACTIVE_LOW}};

    logic [3:0]       bank_en;
    logic [N_OUT-1:0] next_y;
    logic [N_OUT-1:0] y_q;

    // Upper bits pick one of four banks; only that bank's 2-to-4 is enabled.
    decoder_2to4 u_bank_sel (
        .sel ({d, c}),
        .en  (en),
        .y   (bank_en)
    );

    for (genvar g = 0; g < 4; g++) begin : g_bank
        decoder_2to4 u_line_sel (
            .sel ({b, a}),
            .en  (bank_en[g]),
            .y   (next_y[g*4 +: 4])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            y_q <= POL_MASK;
        end else begin
            y_q <= next_y ^ POL_MASK;
        end
    end

    assign y0  = y_q[0];
    assign y1  = y_q[1];
    assign y2  = y_q[2];
    assign y3  = y_q[3];
    assign y4  = y_q[4];
    assign y5  = y_q[5];
    assign y6  = y_q[6];
    assign y7  = y_q[7];
    assign y8  = y_q[8];
    assign y9  = y_q[9];
    assign y10 = y_q[10];
    assign y11 = y_q[11];
    assign y12 = y_q[12];
    assign y13 = y_q[13];
    assign y14 = y_q[14];
    assign y15 = y_q[15];

endmodule

// File: tb/tb_decoder_4to16.sv
// Bench for decoder_4to16: both output polarities driven in lockstep from one vector table.
module tb_decoder_4to16;

    typedef struct packed {
        logic        rst;
        logic        en;
        logic [3:0]  sel;
        logic [15:0] exp;
    } vec_t;

    logic clk;
    logic rst;
    logic en;
    logic d;
    logic c;
    logic b;
    logic a;
    logic [15:0] y_hi;
    logic [15:0] y_lo;

    int n_tests;
    int n_fail;
    logic [15:0] exp_q[$];

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    decoder_4to16 #(.OUT_ACTIVE_LOW(1'b0)) dut_hi (
        .clk(clk), .rst(rst), .en(en), .d(d), .c(c), .b(b), .a(a),
        .y0(y_hi[0]),   .y1(y_hi[1]),   .y2(y_hi[2]),   .y3(y_hi[3]),
        .y4(y_hi[4]),   .y5(y_hi[5]),   .y6(y_hi[6]),   .y7(y_hi[7]),
        .y8(y_hi[8]),   .y9(y_hi[9]),   .y10(y_hi[10]), .y11(y_hi[11]),
        .y12(y_hi[12]), .y13(y_hi[13]), .y14(y_hi[14]), .y15(y_hi[15])
    );

    decoder_4to16 #(.OUT_ACTIVE_LOW(1'b1)) dut_lo (
        .clk(clk), .rst(rst), .en(en), .d(d), .c(c), .b(b), .a(a),
        .y0(y_lo[0]),   .y1(y_lo[1]),   .y2(y_lo[2]),   .y3(y_lo[3]),
        .y4(y_lo[4]),   .y5(y_lo[5]),   .y6(y_lo[6]),   .y7(y_lo[7]),
        .y8(y_lo[8]),   .y9(y_lo[9]),   .y10(y_lo[10]), .y11(y_lo[11]),
        .y12(y_lo[12]), .y13(y_lo[13]), .y14(y_lo[14]), .y15(y_lo[15])
    );

    // driver tasks
    task automatic drive(input logic r, input logic e, input logic [3:0] s);
        rst = r;
        en  = e;
        {d, c, b, a} = s;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // scoreboard
    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %04h expected %04h", name, act, exp);
        end
    endtask

    task automatic check_both(input string name, input logic [15:0] exp);
        check({name, "/hi"}, y_hi, exp);
        check({name, "/lo"}, y_lo, ~exp);
    endtask

    vec_t vecs[$];

    initial begin
        vec_t v;
        logic        r_en;
        logic [3:0]  r_sel;
        logic [15:0] exp_v;
        n_tests = 0;
        n_fail  = 0;
        drive(1'b1, 1'b1, 4'b1010);

        // reset held two cycles with a live select, then first decode
        vecs.push_back('{rst: 1'b1, en: 1'b1, sel: 4'b1010, exp: 16'h0000});
        vecs.push_back('{rst: 1'b1, en: 1'b1, sel: 4'b1010, exp: 16'h0000});
        vecs.push_back('{rst: 1'b0, en: 1'b1, sel: 4'b1010, exp: 16'h0400});
        // exhaustive sweep, one select per cycle
        vecs.push_back('{rst: 1'b0, en: 1'b1, sel: 4'd0,  exp: 16'h0001});
        vecs.push_back('{rst: 1'b0, en: 1'b1, sel: 4'd1,  exp: 16'h0002});
        vecs.push_back('{rst: 1'b0, en: 1'b1, sel: 4'd2,  exp: 16'h0004});
        vecs.push_back('{rst: 1'b0, en: 1'b1, sel: 4'd3,  exp: 16'h0008});
        vecs.push_back('{rst: 1'b0, en: 1'b1, sel: 4'd4,  exp: 16'h0010});
        vecs.push_back('{rst: 1'b0, en: 1'b1, sel: 4'd5,  exp: 16'h0020});
        vecs.push_back('{rst: 1'b0, en: 1'b1, sel: 4'd6,  exp: 16'h0040});
        vecs.push_back('{rst: 1'b0, en: 1'b1, sel: 4'd7,  exp: 16'h0080});
        vecs.push_back('{rst: 1'b0, en: 1'b1, sel: 4'd8,  exp: 16'h0100});
        vecs.push_back('{rst: 1'b0, en: 1'b1, sel: 4'd9,  exp: 16'h0200});
        vecs.push_back('{rst: 1'b0, en: 1'b1, sel: 4'd10, exp: 16'h0400});
        vecs.push_back('{rst: 1'b0, en: 1'b1, sel: 4'd11, exp: 16'h0800});
        vecs.push_back('{rst: 1'b0, en: 1'b1, sel: 4'd12, exp: 16'h1000});
        vecs.push_back('{rst: 1'b0, en: 1'b1, sel: 4'd13, exp: 16'h2000});
        vecs.push_back('{rst: 1'b0, en: 1'b1, sel: 4'd14, exp: 16'h4000});
        vecs.push_back('{rst: 1'b0, en: 1'b1, sel: 4'd15, exp: 16'h8000});
        // enable gating
        vecs.push_back('{rst: 1'b0, en: 1'b0, sel: 4'b0111, exp: 16'h0000});
        vecs.push_back('{rst: 1'b0, en: 1'b1, sel: 4'b0111, exp: 16'h0080});
        // mid-operation reset, then enable drop
        vecs.push_back('{rst: 1'b0, en: 1'b1, sel: 4'b1100, exp: 16'h1000});
        vecs.push_back('{rst: 1'b1, en: 1'b1, sel: 4'b1100, exp: 16'h0000});
        vecs.push_back('{rst: 1'b0, en: 1'b1, sel: 4'b1100, exp: 16'h1000});
        vecs.push_back('{rst: 1'b0, en: 1'b0, sel: 4'b1100, exp: 16'h0000});
        vecs.push_back('{rst: 1'b0, en: 1'b1, sel: 4'b0011, exp: 16'h0008});

        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            drive(v.rst, v.en, v.sel);
            step();
            check($sformatf("vec%0d_sel%0d", i, v.sel), y_hi, v.exp);
            check($sformatf("vec%0d_sel%0d_lo", i, v.sel), y_lo, ~v.exp);
        end

        // hold: outputs stay put while inputs are unchanged
        drive(1'b0, 1'b1, 4'b0011);
        step();
        step();
        check_both("hold_sel3", 16'h0008);

        // reset while disabled still forces the inactive level
        drive(1'b1, 1'b0, 4'b1111);
        step();
        check_both("rst_en0", 16'h0000);

        // random stream with one-cycle-delayed expectation
        drive(1'b0, 1'b1, 4'b0000);
        for (int i = 0; i < 1000; i++) begin
            r_en  = ($urandom_range(0, 3) != 0);
            r_sel = 4'($urandom_range(0, 15));
            exp_v = r_en ? (16'h0001 << r_sel) : 16'h0000;
            exp_q.push_back(exp_v);
            drive(1'b0, r_en, r_sel);
            step();
            exp_v = exp_q.pop_front();
            check($sformatf("rand%0d", i), y_hi, exp_v);
            check($sformatf("rand%0d_lo", i), y_lo, ~exp_v);
            n_tests++;
            if ($countones(y_hi) > 1 || $countones(~y_lo) > 1) begin
                n_fail++;
                $display("FAIL onehot%0d: got hi=%04h lo=%04h expected at most one active", i, y_hi, y_lo);
            end
        end

        // final report
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
